// File: rtl/pair_writeback_pkg.sv
// Shared types and constants for the pair write-back stage: state encoding,
// default widths and the legal read-latency range.
`default_nettype none

package pipeline_pkg;

  localparam int PW_ADDR_SIZE   = 5;
  localparam int PW_DATA_WIDTH  = 16;
  localparam int PW_RD_LATENCY  = 2;
  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pw_state_e;

  function automatic logic [3:0] state_code(input pw_state_e s);
    return {2'b00, s};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pair_writeback_if.sv
// Read-request / result-write bundle between the read driver, RAM and the
// pair write-back stage.
`default_nettype none

interface pair_writeback_if #(
  parameter int ADDR_SIZE  = 5,
  parameter int DATA_WIDTH = 16
) ();

  logic                  i_rden;
  logic [ADDR_SIZE-1:0]  i_rdaddr_A;
  logic [DATA_WIDTH-1:0] i_rddata_A;
  logic [DATA_WIDTH-1:0] i_rddata_B;
  logic                  o_wren;
  logic [ADDR_SIZE-1:0]  o_wraddr;
  logic [DATA_WIDTH-1:0] o_wrdata;
  logic                  o_busy;
  logic                  o_done;
  logic [ADDR_SIZE-1:0]  o_pair_cnt;
  logic                  o_ovf;
  logic [3:0]            o_state_HEX0;

  // The write-back block consumes requests and produces results.
  modport slave (
    input  i_rden, i_rdaddr_A, i_rddata_A, i_rddata_B,
    output o_wren, o_wraddr, o_wrdata, o_busy, o_done,
           o_pair_cnt, o_ovf, o_state_HEX0
  );

  modport master (
    output i_rden, i_rdaddr_A, i_rddata_A, i_rddata_B,
    input  o_wren, o_wraddr, o_wrdata, o_busy, o_done,
           o_pair_cnt, o_ovf, o_state_HEX0
  );

endinterface

`default_nettype wire

// File: rtl/pair_writeback_rd_delay_line.sv
// Valid + address shift register matching the RAM read latency; stage 0
// samples the request, the last stage lines up with the returned data.
`default_nettype none

module rd_delay_line #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              any_valid_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      addr_q[0]  <= addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign valid_o     = valid_q[DEPTH-1];
  assign addr_o      = addr_q[DEPTH-1];
  assign any_valid_o = |valid_q;

endmodule

`default_nettype wire

// File: rtl/pair_writeback.sv
// +--------------------------------------------------------------------------+
// | pair_writeback                                                           |
// | Tracks read requests through the RAM latency, sums the operand pair and  |
// | writes it at the pair index; reports burst busy/done, count, overflow.   |
// | Option: PAIR_WB_SATURATE_EN clamps overflowing sums to all ones.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pair_writeback
  import pipeline_pkg::*;
#(
  parameter int ADDR_SIZE  = PW_ADDR_SIZE,
  parameter int DATA_WIDTH = PW_DATA_WIDTH,
  parameter int RD_LATENCY = PW_RD_LATENCY
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  pair_writeback_if.slave  bus
);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("pair_writeback: RD_LATENCY must be within 1..4");
  end

  logic                  dl_valid;
  logic [ADDR_SIZE-1:0]  dl_addr;
  logic                  dl_any;

  pw_state_e             state_q, state_d;
  logic                  clear_cnt;
  logic                  wren_q, wren_d;
  logic [ADDR_SIZE-1:0]  wraddr_q, wraddr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic [ADDR_SIZE-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH:0]   sum_full;
  logic                  carry;
  logic [DATA_WIDTH-1:0] sum_res;

  rd_delay_line #(
    .DEPTH  (RD_LATENCY),
    .ADDR_W (ADDR_SIZE)
  ) u_rd_delay_line (
    .clk_i       (i_CLK),
    .rst_ni      (i_RST_N),
    .valid_i     (bus.i_rden),
    .addr_i      (bus.i_rdaddr_A),
    .valid_o     (dl_valid),
    .addr_o      (dl_addr),
    .any_valid_o (dl_any)
  );

  always_comb begin
    sum_full = {1'b0, bus.i_rddata_A} + {1'b0, bus.i_rddata_B};
    carry    = sum_full[DATA_WIDTH];
`ifdef PAIR_WB_SATURATE_EN
    sum_res  = carry ? '1 : sum_full[DATA_WIDTH-1:0];
`else
    sum_res  = sum_full[DATA_WIDTH-1:0];
`endif
  end

  // Leaving DRAIN only needs the delay line empty: its last stage is what
  // would load the output stage, so the write register empties on that edge.
  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_rden) begin
          state_d   = RUN;
          clear_cnt = 1'b1;
        end
      end
      RUN: begin
        if (!bus.i_rden) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.i_rden)   state_d = RUN;
        else if (!dl_any) state_d = DONE;
      end
      DONE: begin
        if (bus.i_rden) begin
          state_d   = RUN;
          clear_cnt = 1'b1;
        end else begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wren_d   = dl_valid;
    wraddr_d = dl_valid ? (dl_addr >> 1) : wraddr_q;
    wrdata_d = dl_valid ? sum_res : wrdata_q;
    cnt_d    = (clear_cnt ? '0 : cnt_q) + ADDR_SIZE'(dl_valid);
    ovf_d    = (clear_cnt ? 1'b0 : ovf_q) | (dl_valid & carry);
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= IDLE;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.o_wren       = wren_q;
  assign bus.o_wraddr     = wraddr_q;
  assign bus.o_wrdata     = wrdata_q;
  assign bus.o_busy       = (state_q == RUN) || (state_q == DRAIN);
  assign bus.o_done       = (state_q == DONE);
  assign bus.o_pair_cnt   = cnt_q;
  assign bus.o_ovf        = ovf_q;
  assign bus.o_state_HEX0 = state_code(state_q);

endmodule

`default_nettype wire

// File: tb/tb_pair_writeback.sv
// Directed self-checking bench for pair_writeback (RD_LATENCY = 2).
`default_nettype none

module tb_pair_writeback;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

`ifdef PAIR_WB_SATURATE_EN
  localparam logic [15:0] OVF_SUM = 16'hFFFF;
`else
  localparam logic [15:0] OVF_SUM = 16'h0001;
`endif

  always #5 clk = ~clk;

  pair_writeback_if #(.ADDR_SIZE(5), .DATA_WIDTH(16)) bus ();

  pair_writeback #(
    .ADDR_SIZE  (5),
    .DATA_WIDTH (16),
    .RD_LATENCY (2)
  ) dut (
    .i_CLK   (clk),
    .i_RST_N (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_rden       = 1'($urandom);
      bus.i_rdaddr_A   = 5'($urandom);
      bus.i_rddata_A   = 16'($urandom);
      bus.i_rddata_B   = 16'($urandom);
      tick();
    end
    checks++; if (bus.o_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%0h exp=0", bus.o_wren); end
    checks++; if (bus.o_wraddr !== 5'd0) begin errors++; $display("FAIL reset_wraddr got=%0h exp=0", bus.o_wraddr); end
    checks++; if (bus.o_wrdata !== 16'd0) begin errors++; $display("FAIL reset_wrdata got=%0h exp=0", bus.o_wrdata); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", bus.o_busy); end
    checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", bus.o_done); end
    checks++; if (bus.o_pair_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got=%0h exp=0", bus.o_pair_cnt); end
    checks++; if (bus.o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0h exp=0", bus.o_ovf); end
    checks++; if (bus.o_state_HEX0 !== 4'd0) begin errors++; $display("FAIL reset_state got=%0h exp=0", bus.o_state_HEX0); end
    bus.i_rden = 1'b0;
    rst_n      = 1'b1;
    tick();
    tick();
    checks++; if (bus.o_state_HEX0 !== 4'd0) begin errors++; $display("FAIL release_state got=%0h exp=0", bus.o_state_HEX0); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL release_busy got=%0h exp=0", bus.o_busy); end
    checks++; if (bus.o_wren !== 1'b0) begin errors++; $display("FAIL release_wren got=%0h exp=0", bus.o_wren); end
  endtask

  task automatic test_burst();
    logic [3:0] st_exp [7] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd0};
    logic [4:0] wa_exp [7] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd0, 5'd0};
    logic [0:6] wr_exp = 7'b0011100;
    logic [0:6] dn_exp = 7'b0000010;
    logic [0:6] bz_exp = 7'b1111100;
    bus.i_rddata_A = 16'd3;
    bus.i_rddata_B = 16'd4;
    for (int i = 0; i < 7; i++) begin
      bus.i_rden     = (i < 3);
      bus.i_rdaddr_A = 5'(2 * i);
      tick();
      checks++; if (bus.o_state_HEX0 !== st_exp[i]) begin errors++; $display("FAIL burst_state[%0d] got=%0h exp=%0h", i, bus.o_state_HEX0, st_exp[i]); end
      checks++; if (bus.o_wren !== wr_exp[i]) begin errors++; $display("FAIL burst_wren[%0d] got=%0h exp=%0h", i, bus.o_wren, wr_exp[i]); end
      checks++; if (bus.o_done !== dn_exp[i]) begin errors++; $display("FAIL burst_done[%0d] got=%0h exp=%0h", i, bus.o_done, dn_exp[i]); end
      checks++; if (bus.o_busy !== bz_exp[i]) begin errors++; $display("FAIL burst_busy[%0d] got=%0h exp=%0h", i, bus.o_busy, bz_exp[i]); end
      if (wr_exp[i]) begin
        checks++; if (bus.o_wraddr !== wa_exp[i]) begin errors++; $display("FAIL burst_wraddr[%0d] got=%0h exp=%0h", i, bus.o_wraddr, wa_exp[i]); end
        checks++; if (bus.o_wrdata !== 16'd7) begin errors++; $display("FAIL burst_wrdata[%0d] got=%0h exp=7", i, bus.o_wrdata); end
      end
      if (i == 5) begin
        checks++; if (bus.o_pair_cnt !== 5'd3) begin errors++; $display("FAIL burst_cnt got=%0d exp=3", bus.o_pair_cnt); end
        checks++; if (bus.o_ovf !== 1'b0) begin errors++; $display("FAIL burst_ovf got=%0h exp=0", bus.o_ovf); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [3:0] st_exp [5] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd0};
    logic [0:4] wr_exp = 5'b00100;
    logic [0:4] dn_exp = 5'b00010;
    bus.i_rddata_A = 16'hFFFF;
    bus.i_rddata_B = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      bus.i_rden     = (i == 0);
      bus.i_rdaddr_A = 5'd6;
      tick();
      checks++; if (bus.o_state_HEX0 !== st_exp[i]) begin errors++; $display("FAIL ovf_state[%0d] got=%0h exp=%0h", i, bus.o_state_HEX0, st_exp[i]); end
      checks++; if (bus.o_wren !== wr_exp[i]) begin errors++; $display("FAIL ovf_wren[%0d] got=%0h exp=%0h", i, bus.o_wren, wr_exp[i]); end
      checks++; if (bus.o_done !== dn_exp[i]) begin errors++; $display("FAIL ovf_done[%0d] got=%0h exp=%0h", i, bus.o_done, dn_exp[i]); end
      if (i == 0) begin
        checks++; if (bus.o_pair_cnt !== 5'd0) begin errors++; $display("FAIL ovf_cnt_clear got=%0d exp=0", bus.o_pair_cnt); end
      end
      if (i == 2) begin
        checks++; if (bus.o_wraddr !== 5'd3) begin errors++; $display("FAIL ovf_wraddr got=%0h exp=3", bus.o_wraddr); end
        checks++; if (bus.o_wrdata !== OVF_SUM) begin errors++; $display("FAIL ovf_wrdata got=%0h exp=%0h", bus.o_wrdata, OVF_SUM); end
        checks++; if (bus.o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0h exp=1", bus.o_ovf); end
        checks++; if (bus.o_pair_cnt !== 5'd1) begin errors++; $display("FAIL ovf_cnt got=%0d exp=1", bus.o_pair_cnt); end
      end
      if (i == 3) begin
        checks++; if (bus.o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0h exp=1", bus.o_ovf); end
      end
    end
  endtask

  task automatic test_gap();
    logic [3:0] st_exp [7] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd2, 4'd3, 4'd0};
    logic [4:0] ad_in  [7] = '{5'd8, 5'd0, 5'd10, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [4:0] wa_exp [7] = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd5, 5'd0, 5'd0};
    logic [0:6] rd_in  = 7'b1010000;
    logic [0:6] wr_exp = 7'b0010100;
    logic [0:6] dn_exp = 7'b0000010;
    bus.i_rddata_A = 16'd5;
    bus.i_rddata_B = 16'd6;
    for (int i = 0; i < 7; i++) begin
      bus.i_rden     = rd_in[i];
      bus.i_rdaddr_A = ad_in[i];
      tick();
      checks++; if (bus.o_state_HEX0 !== st_exp[i]) begin errors++; $display("FAIL gap_state[%0d] got=%0h exp=%0h", i, bus.o_state_HEX0, st_exp[i]); end
      checks++; if (bus.o_wren !== wr_exp[i]) begin errors++; $display("FAIL gap_wren[%0d] got=%0h exp=%0h", i, bus.o_wren, wr_exp[i]); end
      checks++; if (bus.o_done !== dn_exp[i]) begin errors++; $display("FAIL gap_done[%0d] got=%0h exp=%0h", i, bus.o_done, dn_exp[i]); end
      if (wr_exp[i]) begin
        checks++; if (bus.o_wraddr !== wa_exp[i]) begin errors++; $display("FAIL gap_wraddr[%0d] got=%0h exp=%0h", i, bus.o_wraddr, wa_exp[i]); end
        checks++; if (bus.o_wrdata !== 16'd11) begin errors++; $display("FAIL gap_wrdata[%0d] got=%0h exp=b", i, bus.o_wrdata); end
      end
      if (i == 0) begin
        checks++; if (bus.o_ovf !== 1'b0) begin errors++; $display("FAIL gap_ovf_clear got=%0h exp=0", bus.o_ovf); end
      end
      if (i == 5) begin
        checks++; if (bus.o_pair_cnt !== 5'd2) begin errors++; $display("FAIL gap_cnt got=%0d exp=2", bus.o_pair_cnt); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st_exp [9] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd1, 4'd2, 4'd2, 4'd3, 4'd0};
    logic [4:0] ad_in  [9] = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [4:0] wa_exp [9] = '{5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0};
    logic [4:0] ct_exp [9] = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1};
    logic [0:8] rd_in  = 9'b100010000;
    logic [0:8] wr_exp = 9'b001000100;
    logic [0:8] dn_exp = 9'b000100010;
    bus.i_rddata_A = 16'd1;
    bus.i_rddata_B = 16'd2;
    for (int i = 0; i < 9; i++) begin
      bus.i_rden     = rd_in[i];
      bus.i_rdaddr_A = ad_in[i];
      tick();
      checks++; if (bus.o_state_HEX0 !== st_exp[i]) begin errors++; $display("FAIL b2b_state[%0d] got=%0h exp=%0h", i, bus.o_state_HEX0, st_exp[i]); end
      checks++; if (bus.o_wren !== wr_exp[i]) begin errors++; $display("FAIL b2b_wren[%0d] got=%0h exp=%0h", i, bus.o_wren, wr_exp[i]); end
      checks++; if (bus.o_done !== dn_exp[i]) begin errors++; $display("FAIL b2b_done[%0d] got=%0h exp=%0h", i, bus.o_done, dn_exp[i]); end
      checks++; if (bus.o_pair_cnt !== ct_exp[i]) begin errors++; $display("FAIL b2b_cnt[%0d] got=%0d exp=%0d", i, bus.o_pair_cnt, ct_exp[i]); end
      if (wr_exp[i]) begin
        checks++; if (bus.o_wraddr !== wa_exp[i]) begin errors++; $display("FAIL b2b_wraddr[%0d] got=%0h exp=%0h", i, bus.o_wraddr, wa_exp[i]); end
        checks++; if (bus.o_wrdata !== 16'd3) begin errors++; $display("FAIL b2b_wrdata[%0d] got=%0h exp=3", i, bus.o_wrdata); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] ea;
    bus.i_rddata_A = 16'd1;
    bus.i_rddata_B = 16'd1;
    for (int i = 0; i < 37; i++) begin
      bus.i_rden     = (i < 33);
      bus.i_rdaddr_A = 5'(30 + 2 * i);
      tick();
      checks++; if (bus.o_wren !== (i >= 2 && i <= 34)) begin errors++; $display("FAIL wrap_wren[%0d] got=%0h", i, bus.o_wren); end
      checks++; if (bus.o_done !== (i == 35)) begin errors++; $display("FAIL wrap_done[%0d] got=%0h", i, bus.o_done); end
      if (i >= 2 && i <= 34) begin
        ea = 5'(30 + 2 * (i - 2));
        ea = ea >> 1;
        checks++; if (bus.o_wraddr !== ea) begin errors++; $display("FAIL wrap_wraddr[%0d] got=%0d exp=%0d", i, bus.o_wraddr, ea); end
        checks++; if (bus.o_pair_cnt !== 5'(i - 1)) begin errors++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", i, bus.o_pair_cnt, 5'(i - 1)); end
      end
      if (i == 2) begin
        checks++; if (bus.o_wraddr !== 5'd15) begin errors++; $display("FAIL wrap_first_wraddr got=%0d exp=15", bus.o_wraddr); end
      end
      if (i == 35) begin
        checks++; if (bus.o_pair_cnt !== 5'd1) begin errors++; $display("FAIL wrap_final_cnt got=%0d exp=1", bus.o_pair_cnt); end
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.i_rddata_A = 16'd2;
    bus.i_rddata_B = 16'd2;
    for (int i = 0; i < 3; i++) begin
      bus.i_rden     = 1'b1;
      bus.i_rdaddr_A = 5'(2 * i);
      tick();
    end
    checks++; if (bus.o_wren !== 1'b1) begin errors++; $display("FAIL midrst_pre_wren got=%0h exp=1", bus.o_wren); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_wren !== 1'b0) begin errors++; $display("FAIL midrst_wren got=%0h exp=0", bus.o_wren); end
    checks++; if (bus.o_state_HEX0 !== 4'd0) begin errors++; $display("FAIL midrst_state got=%0h exp=0", bus.o_state_HEX0); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0h exp=0", bus.o_busy); end
    checks++; if (bus.o_pair_cnt !== 5'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", bus.o_pair_cnt); end
    checks++; if (bus.o_wrdata !== 16'd0) begin errors++; $display("FAIL midrst_wrdata got=%0h exp=0", bus.o_wrdata); end
    bus.i_rden = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus.o_wren !== 1'b0) begin errors++; $display("FAIL midrst_post_wren[%0d] got=%0h exp=0", i, bus.o_wren); end
      checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL midrst_post_done[%0d] got=%0h exp=0", i, bus.o_done); end
      checks++; if (bus.o_state_HEX0 !== 4'd0) begin errors++; $display("FAIL midrst_post_state[%0d] got=%0h exp=0", i, bus.o_state_HEX0); end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.i_rden     = 1'b0;
    bus.i_rdaddr_A = 5'd0;
    bus.i_rddata_A = 16'd0;
    bus.i_rddata_B = 16'd0;
    test_reset();
    test_burst();
    test_overflow();
    test_gap();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
